// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: standby, menu, fan levels 1-3, hurricane exit, timed self-clean.
// One-cycle latency from key/tick to outputs.

module hood_mode_ctrl #(
    parameter int CNT_W              = 8,
    parameter int HURRICANE_SEC      = 60,
    parameter int HURRICANE_EXIT_SEC = 60,
    parameter int CLEAN_SEC          = 180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             power_en,
    input  logic             key_menu,
    input  logic             key_l1,
    input  logic             key_l2,
    input  logic             key_l3,
    input  logic             key_clean,
    output logic [2:0]       state,
    output logic [1:0]       fan_level,
    output logic             clean_active,
    output logic [CNT_W-1:0] countdown,
    output logic             hurricane_avail,
    output logic [6:0]       led
);

    typedef enum logic [2:0] {
        ST_STANDBY = 3'd0,
        ST_MENU    = 3'd1,
        ST_L1      = 3'd2,
        ST_L2      = 3'd3,
        ST_L3      = 3'd4,
        ST_L3_EXIT = 3'd5,
        ST_CLEAN   = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_HURR  = CNT_W'(HURRICANE_SEC);
    localparam logic [CNT_W-1:0] LOAD_EXIT  = CNT_W'(HURRICANE_EXIT_SEC);
    localparam logic [CNT_W-1:0] LOAD_CLEAN = CNT_W'(CLEAN_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_avail;

    logic [2:0] key_count;
    logic       key_ok;
    logic       k_menu, k_l1, k_l2, k_l3, k_clean;
    logic       expire;
    logic       dec_ok;

    // Simultaneous key presses are treated as a glitch and dropped entirely.
    assign key_count = 3'(key_menu) + 3'(key_l1) + 3'(key_l2) + 3'(key_l3) + 3'(key_clean);
    assign key_ok    = (key_count == 3'd1);
    assign k_menu    = key_ok & key_menu;
    assign k_l1      = key_ok & key_l1;
    assign k_l2      = key_ok & key_l2;
    assign k_l3      = key_ok & key_l3;
    assign k_clean   = key_ok & key_clean;

    assign expire = tick_1hz && (countdown == CNT_ONE);
    assign dec_ok = tick_1hz && (countdown != '0);

    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = countdown;
        nxt_avail = hurricane_avail;
        if (!power_en) begin
            nxt_state = ST_STANDBY;
            nxt_cnt   = '0;
            nxt_avail = 1'b1;
        end else begin
            case (cur_state)
                ST_STANDBY: begin
                    if (k_menu) nxt_state = ST_MENU;
                end
                ST_MENU: begin
                    if (k_l1) begin
                        nxt_state = ST_L1;
                    end else if (k_l2) begin
                        nxt_state = ST_L2;
                    end else if (k_l3 && hurricane_avail) begin
                        nxt_state = ST_L3;
                        nxt_cnt   = LOAD_HURR;
                        nxt_avail = 1'b0;
                    end else if (k_clean) begin
                        nxt_state = ST_CLEAN;
                        nxt_cnt   = LOAD_CLEAN;
                    end else if (k_menu) begin
                        nxt_state = ST_STANDBY;
                    end
                end
                ST_L1: begin
                    if (k_menu)    nxt_state = ST_MENU;
                    else if (k_l2) nxt_state = ST_L2;
                end
                ST_L2: begin
                    if (k_menu)    nxt_state = ST_MENU;
                    else if (k_l1) nxt_state = ST_L1;
                end
                ST_L3: begin
                    // Expiry outranks the menu key; a reload swallows any same-cycle tick.
                    if (expire) begin
                        nxt_state = ST_L2;
                        nxt_cnt   = '0;
                    end else if (k_menu) begin
                        nxt_state = ST_L3_EXIT;
                        nxt_cnt   = LOAD_EXIT;
                    end else if (dec_ok) begin
                        nxt_cnt = countdown - CNT_ONE;
                    end
                end
                ST_L3_EXIT, ST_CLEAN: begin
                    if (expire) begin
                        nxt_state = ST_STANDBY;
                        nxt_cnt   = '0;
                    end else if (dec_ok) begin
                        nxt_cnt = countdown - CNT_ONE;
                    end
                end
                default: begin
                    nxt_state = ST_STANDBY;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Display outputs are decoded from the next state so they land with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state       <= ST_STANDBY;
            countdown       <= '0;
            hurricane_avail <= 1'b1;
            fan_level       <= 2'd0;
            clean_active    <= 1'b0;
            led             <= 7'b0000001;
        end else begin
            cur_state       <= nxt_state;
            countdown       <= nxt_cnt;
            hurricane_avail <= nxt_avail;
            clean_active    <= (nxt_state == ST_CLEAN);
            led             <= (nxt_state == ST_ILLEGAL) ? 7'b0000000 : (7'b0000001 << nxt_state);
            case (nxt_state)
                ST_L1:               fan_level <= 2'd1;
                ST_L2:               fan_level <= 2'd2;
                ST_L3, ST_L3_EXIT:   fan_level <= 2'd3;
                default:             fan_level <= 2'd0;
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with short timer parameters (3/2/4 seconds).
module tb_hood_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       power_en;
    logic       key_menu, key_l1, key_l2, key_l3, key_clean;
    logic [2:0] state;
    logic [1:0] fan_level;
    logic       clean_active;
    logic [7:0] countdown;
    logic       hurricane_avail;
    logic [6:0] led;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] K_NONE  = 5'b00000;
    localparam logic [4:0] K_MENU  = 5'b10000;
    localparam logic [4:0] K_L1    = 5'b01000;
    localparam logic [4:0] K_L2    = 5'b00100;
    localparam logic [4:0] K_L3    = 5'b00010;
    localparam logic [4:0] K_CLEAN = 5'b00001;

    hood_mode_ctrl #(
        .CNT_W(8), .HURRICANE_SEC(3), .HURRICANE_EXIT_SEC(2), .CLEAN_SEC(4)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .power_en(power_en),
        .key_menu(key_menu), .key_l1(key_l1), .key_l2(key_l2), .key_l3(key_l3),
        .key_clean(key_clean), .state(state), .fan_level(fan_level),
        .clean_active(clean_active), .countdown(countdown),
        .hurricane_avail(hurricane_avail), .led(led)
    );

    always #5 clk = ~clk;

    // Apply one cycle of key/tick inputs, then release pulses just after the edge.
    task automatic step(input logic [4:0] keys, input logic t);
        {key_menu, key_l1, key_l2, key_l3, key_clean} = keys;
        tick_1hz = t;
        @(posedge clk);
        #1;
        {key_menu, key_l1, key_l2, key_l3, key_clean} = K_NONE;
        tick_1hz = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        power_en = 1'b0;
        {key_menu, key_l1, key_l2, key_l3, key_clean} = K_NONE;
        tick_1hz = 1'b0;
        step(K_NONE, 1'b0);
        step(K_NONE, 1'b0);
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(countdown), 0);
        chk("rst_avail", 32'(hurricane_avail), 1);
        chk("rst_fan", 32'(fan_level), 0);
        chk("rst_clean", 32'(clean_active), 0);
        chk("rst_led", 32'(led), 32'h01);
        rst = 1'b0;
        power_en = 1'b1;
        step(K_NONE, 1'b0);
        chk("idle_state", 32'(state), 0);
        step(K_L2, 1'b0);
        chk("standby_ignores_l2", 32'(state), 0);

        step(K_MENU, 1'b0);
        chk("menu_state", 32'(state), 1);
        chk("menu_led", 32'(led), 32'h02);
        step(K_L2, 1'b0);
        chk("l2_state", 32'(state), 3);
        chk("l2_fan", 32'(fan_level), 2);
        chk("l2_led", 32'(led), 32'h08);

        step(K_MENU, 1'b0);
        step(K_L3, 1'b0);
        chk("l3_state", 32'(state), 4);
        chk("l3_cnt", 32'(countdown), 3);
        chk("l3_avail", 32'(hurricane_avail), 0);
        chk("l3_fan", 32'(fan_level), 3);
        step(K_NONE, 1'b1);
        chk("l3_tick1", 32'(countdown), 2);
        step(K_NONE, 1'b1);
        chk("l3_tick2", 32'(countdown), 1);
        step(K_NONE, 1'b1);
        chk("l3_expire_state", 32'(state), 3);
        chk("l3_expire_cnt", 32'(countdown), 0);
        chk("l3_expire_fan", 32'(fan_level), 2);
        step(K_MENU, 1'b0);
        step(K_L3, 1'b0);
        chk("l3_locked", 32'(state), 1);
        chk("l3_locked_avail", 32'(hurricane_avail), 0);

        power_en = 1'b0;
        step(K_NONE, 1'b0);
        chk("pwr_off_state", 32'(state), 0);
        chk("pwr_off_avail", 32'(hurricane_avail), 1);
        power_en = 1'b1;
        step(K_MENU, 1'b0);
        step(K_L3, 1'b0);
        chk("l3b_cnt", 32'(countdown), 3);
        step(K_MENU, 1'b0);
        chk("exit_state", 32'(state), 5);
        chk("exit_cnt", 32'(countdown), 2);
        chk("exit_fan", 32'(fan_level), 3);
        chk("exit_led", 32'(led), 32'h20);
        step(K_L1, 1'b0);
        chk("exit_ignores_key", 32'(state), 5);
        step(K_NONE, 1'b1);
        chk("exit_tick1", 32'(countdown), 1);
        step(K_NONE, 1'b1);
        chk("exit_done_state", 32'(state), 0);
        chk("exit_done_fan", 32'(fan_level), 0);
        chk("exit_done_cnt", 32'(countdown), 0);

        step(K_MENU, 1'b0);
        step(K_CLEAN, 1'b0);
        chk("clean_state", 32'(state), 6);
        chk("clean_cnt", 32'(countdown), 4);
        chk("clean_active", 32'(clean_active), 1);
        chk("clean_fan", 32'(fan_level), 0);
        chk("clean_led", 32'(led), 32'h40);
        step(K_MENU, 1'b0);
        chk("clean_ignores_key", 32'(state), 6);
        chk("clean_ignores_key_cnt", 32'(countdown), 4);
        step(K_NONE, 1'b1);
        chk("clean_tick1", 32'(countdown), 3);
        step(K_NONE, 1'b1);
        chk("clean_tick2", 32'(countdown), 2);
        step(K_NONE, 1'b1);
        chk("clean_tick3", 32'(countdown), 1);
        step(K_NONE, 1'b1);
        chk("clean_done_state", 32'(state), 0);
        chk("clean_done_active", 32'(clean_active), 0);

        step(K_MENU, 1'b0);
        step(K_CLEAN, 1'b0);
        step(K_NONE, 1'b1);
        step(K_NONE, 1'b1);
        chk("clean_mid_cnt", 32'(countdown), 2);
        chk("avail_before_drop", 32'(hurricane_avail), 0);
        power_en = 1'b0;
        step(K_NONE, 1'b0);
        chk("drop_state", 32'(state), 0);
        chk("drop_cnt", 32'(countdown), 0);
        chk("drop_avail", 32'(hurricane_avail), 1);
        power_en = 1'b1;

        step(K_MENU, 1'b0);
        step(K_L3, 1'b0);
        step(K_NONE, 1'b1);
        step(K_NONE, 1'b1);
        chk("race_pre_cnt", 32'(countdown), 1);
        step(K_MENU, 1'b1);
        chk("race_state", 32'(state), 3);
        chk("race_cnt", 32'(countdown), 0);

        step(K_MENU, 1'b0);
        chk("back_to_menu", 32'(state), 1);
        step(K_L1 | K_L2, 1'b0);
        chk("multi_key_state", 32'(state), 1);
        step(K_L1, 1'b0);
        chk("l1_state", 32'(state), 2);
        chk("l1_fan", 32'(fan_level), 1);
        step(K_L3, 1'b0);
        chk("l1_ignores_l3", 32'(state), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
